// File: rtl/tensor_streamer.sv
// tensor_streamer: captures a 3x3 tensor on a load handshake and replays it
// one element per accepted beat, with row/col address, over valid/ready.
module tensor_streamer #(
    parameter int WIDTH = 17
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0][2:0][WIDTH-1:0]   tensor_in,
    input  logic                         col_major,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2:0]                   row_addr,
    output logic [2:0]                   col_addr,
    output logic [WIDTH-1:0]             data_out,
    output logic                         last,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [2:0][2:0][WIDTH-1:0]   shadow;
    logic                         order_cm;
    logic [3:0]                   beat;
    logic                         load_accept;
    logic                         beat_accept;
    logic                         final_beat;
    logic [2:0]                   row_next;
    logic [2:0]                   col_next;

    // Handshake decode, next-state logic and next element address.
    always_comb begin
        state_next  = state;
        in_ready    = (state == IDLE) && !rst;
        load_accept = in_valid && in_ready;
        beat_accept = out_valid && out_ready;
        final_beat  = (beat == 4'd8);
        row_next    = row_addr;
        col_next    = col_addr;

        case (state)
            IDLE:    if (load_accept) state_next = STREAM;
            STREAM:  if (beat_accept && final_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Walk the fast index first; it wraps at 2 and carries into the slow one.
        if (order_cm) begin
            if (row_addr == 3'd2) begin
                row_next = 3'd0;
                col_next = col_addr + 3'd1;
            end else begin
                row_next = row_addr + 3'd1;
            end
        end else begin
            if (col_addr == 3'd2) begin
                col_next = 3'd0;
                row_next = row_addr + 3'd1;
            end else begin
                col_next = col_addr + 3'd1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Shadow capture, beat counter and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            order_cm  <= 1'b0;
            beat      <= '0;
            out_valid <= 1'b0;
            row_addr  <= '0;
            col_addr  <= '0;
            data_out  <= '0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_accept) begin
                shadow    <= tensor_in;
                order_cm  <= col_major;
                beat      <= '0;
                out_valid <= 1'b1;
                busy      <= 1'b1;
                row_addr  <= '0;
                col_addr  <= '0;
                data_out  <= tensor_in[0][0];
                last      <= 1'b0;
            end else if (beat_accept) begin
                if (final_beat) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    last      <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    beat     <= beat + 4'd1;
                    row_addr <= row_next;
                    col_addr <= col_next;
                    data_out <= shadow[row_next[1:0]][col_next[1:0]];
                    last     <= (beat == 4'd7);
                end
            end
        end
    end

endmodule

// File: tb/tb_tensor_streamer.sv
// tb_tensor_streamer: scoreboard bench; loads push expected beats, a monitor
// pops and compares on every accepted beat and checks done/stall behaviour.
module tb_tensor_streamer;

    localparam int W = 17;

    typedef logic [2:0][2:0][W-1:0] tensor_t;
    typedef struct packed {
        logic [2:0]   r;
        logic [2:0]   c;
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    tensor_t        tensor_in;
    logic           col_major;
    logic           in_valid;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     row_addr;
    logic [2:0]     col_addr;
    logic [W-1:0]   data_out;
    logic           last;
    logic           busy;
    logic           done;

    int unsigned    n_vec = 0;
    int unsigned    n_fail = 0;
    beat_t          sb[$];
    beat_t          mon_e;
    int unsigned    acc_count = 0;
    int unsigned    base_cnt = 0;
    int unsigned    stall_cnt = 0;
    int unsigned    mode = 0;
    logic [7:0]     lfsr = 8'hA5;
    logic           exp_done = 1'b0;
    logic           stall_hold = 1'b0;
    logic [23:0]    stall_val = '0;
    logic [W-1:0]   builder [3][3];
    tensor_t        t1, t3, tb4, t6;

    tensor_streamer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tensor_in (tensor_in),
        .col_major (col_major),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .row_addr  (row_addr),
        .col_addr  (col_addr),
        .data_out  (data_out),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Present a load, wait (bounded) for acceptance, then queue the 9 expected beats.
    task automatic do_load(input tensor_t t, input logic cm);
        bit ok;
        beat_t e;
        int unsigned r, c;
        ok = 1'b0;
        tensor_in = t;
        col_major = cm;
        in_valid  = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        in_valid  = 1'b0;
        tensor_in = ~t;
        col_major = ~cm;
        check("load_accepted", 32'(ok), 1);
        if (ok) begin
            check("sb_empty_at_load", sb.size(), 0);
            check("first_beat_latency", 32'(out_valid), 1);
            for (int k = 0; k < 9; k++) begin
                r = cm ? k % 3 : k / 3;
                c = cm ? k / 3 : k % 3;
                e.r = r[2:0];
                e.c = c[2:0];
                e.d = t[r][c];
                e.l = (k == 8);
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input int unsigned budget);
        bit seen;
        seen = 1'b0;
        for (int unsigned i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    // Consumer-side ready pattern: always ready, pseudo-random with a 5-cycle stall on beat 4, or held off.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    if ((acc_count - base_cnt) == 3 && stall_cnt < 5) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = lfsr[0] | lfsr[2];
                    end
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pop on accept, stall stability, done pulse and builder writes.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_hold = 1'b0;
                exp_done   = 1'b0;
            end else begin
                if (exp_done) begin
                    check("done_pulse", 32'(done), 1);
                    check("ready_in_done_cycle", 32'(in_ready), 1);
                    check("valid_after_last", 32'(out_valid), 0);
                    check("busy_after_last", 32'(busy), 0);
                    check("last_after_last", 32'(last), 0);
                    exp_done = 1'b0;
                end else begin
                    check("no_spurious_done", 32'(done), 0);
                end
                if (stall_hold && out_valid)
                    check("stall_stable", 32'({row_addr, col_addr, data_out, last}), 32'(stall_val));
                if (out_valid)
                    check("busy_while_valid", 32'(busy), 1);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got beat (%0d,%0d)=%0h, expected none", row_addr, col_addr, data_out);
                    end else begin
                        mon_e = sb.pop_front();
                        check("beat_row", 32'(row_addr), 32'(mon_e.r));
                        check("beat_col", 32'(col_addr), 32'(mon_e.c));
                        check("beat_data", 32'(data_out), 32'(mon_e.d));
                        check("beat_last", 32'(last), 32'(mon_e.l));
                        if (mon_e.l) exp_done = 1'b1;
                    end
                    if (row_addr < 3 && col_addr < 3)
                        builder[row_addr[1:0]][col_addr[1:0]] = data_out;
                    acc_count++;
                end
                stall_hold = out_valid && !out_ready;
                stall_val  = {row_addr, col_addr, data_out, last};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                t1[i][j]  = 17'(3 * i + j + 1);
                t3[i][j]  = 17'(17'h1000 * (i + 1) + 17'h11 * j + 5);
                tb4[i][j] = 17'h1FFFF;
                builder[i][j] = '0;
            end

        // Reset with a concurrent load request: reset wins.
        rst       = 1'b1;
        in_valid  = 1'b1;
        tensor_in = tb4;
        col_major = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_last", 32'(last), 0);
        check("rst_addr_data", 32'({row_addr, col_addr, data_out}), 0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 1);
        check("load_in_rst_discarded", 32'(out_valid), 0);

        // 1: row-major basic stream.
        do_load(t1, 1'b0);
        wait_done(50);

        // 2: column-major stream of the same tensor.
        do_load(t1, 1'b1);
        wait_done(50);

        // 3: backpressure with a stall on beat 4.
        base_cnt  = acc_count;
        stall_cnt = 0;
        mode      = 1;
        do_load(t3, 1'b0);
        wait_done(400);
        check("bp_accept_count", acc_count - base_cnt, 9);
        mode = 0;
        @(posedge clk);
        #1;

        // 4: load request during a stream is held off until IDLE.
        do_load(t3, 1'b1);
        tensor_in = tb4;
        col_major = 1'b0;
        in_valid  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("in_ready_while_busy", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        do_load(tb4, 1'b0);
        wait_done(50);

        // 5: reset after beat 3 is accepted aborts the stream.
        base_cnt = acc_count;
        do_load(t1, 1'b0);
        for (int i = 0; i < 50 && (acc_count - base_cnt) < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("beats_before_reset", acc_count - base_cnt, 3);
        rst  = 1'b1;
        mode = 2;
        sb.delete();
        @(posedge clk);
        #1;
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_outputs", 32'({row_addr, col_addr, data_out, last}), 0);
        check("abort_in_ready", 32'(in_ready), 0);
        rst  = 1'b0;
        mode = 0;
        repeat (3) @(posedge clk);
        #1;
        do_load(t3, 1'b0);
        wait_done(50);

        // 6: round trip into a tensor builder model.
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                t6[i][j]      = 17'($urandom);
                builder[i][j] = '0;
            end
        t6[1][2] = 17'h1FFFF;
        do_load(t6, 1'b1);
        wait_done(50);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                check("round_trip", 32'(builder[i][j]), 32'(t6[i][j]));

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
